// File: rtl/eth_manchester_tx.sv
// rtl/eth_manchester_tx.sv - 10BASE-T Manchester line encoder with TP_IDL and NLP generation
module eth_manchester_tx #(
  parameter int HALF_BIT_CYCLES   = 1,
  parameter int SOI_CYCLES        = 5,
  parameter int NLP_PERIOD_CYCLES = 320000,
  parameter int NLP_WIDTH_CYCLES  = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic bit_en,
  input  logic tx_data,
  input  logic tx_en,
  input  logic tx_idle,
  output logic td_p,
  output logic td_n,
  output logic line_active
);

  // SOI and NLP are never active together, so they share one pulse-length counter.
  localparam int PLS_CYCLES = (SOI_CYCLES > NLP_WIDTH_CYCLES) ? SOI_CYCLES : NLP_WIDTH_CYCLES;
  localparam int HB_W  = (HALF_BIT_CYCLES > 1)   ? $clog2(HALF_BIT_CYCLES)   : 1;
  localparam int NLP_W = (NLP_PERIOD_CYCLES > 1) ? $clog2(NLP_PERIOD_CYCLES) : 1;
  localparam int PLS_W = (PLS_CYCLES > 1)        ? $clog2(PLS_CYCLES)        : 1;

  localparam logic [HB_W-1:0]  HB_MAX  = HB_W'(HALF_BIT_CYCLES - 1);
  localparam logic [NLP_W-1:0] NLP_MAX = NLP_W'(NLP_PERIOD_CYCLES - 1);
  localparam logic [PLS_W-1:0] SOI_MAX = PLS_W'(SOI_CYCLES - 1);
  localparam logic [PLS_W-1:0] WID_MAX = PLS_W'(NLP_WIDTH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NLP,
    ST_DATA,
    ST_SOI
  } state_t;

  state_t           state_q, state_d;
  logic [HB_W-1:0]  hb_q, hb_d;
  logic             phase_q, phase_d;
  logic [NLP_W-1:0] nlp_q, nlp_d;
  logic [PLS_W-1:0] pls_q, pls_d;
  logic             bit_q, bit_d;
  logic             bit_en_q, bit_en_d;
  logic             td_p_q, td_p_d;
  logic             td_n_q, td_n_d;
  logic             line_active_q, line_active_d;
  logic             boundary;

  logic unused_tx_idle;
  assign unused_tx_idle = tx_idle;

  always_comb begin
    hb_d          = (hb_q == HB_MAX) ? '0 : hb_q + HB_W'(1);
    phase_d       = (hb_q == HB_MAX) ? ~phase_q : phase_q;
    boundary      = phase_q && (hb_q == HB_MAX);
    state_d       = state_q;
    nlp_d         = nlp_q;
    pls_d         = pls_q;
    bit_d         = bit_q;

    case (state_q)
      ST_IDLE: begin
        if (nlp_q == NLP_MAX) begin
          state_d = ST_NLP;
          nlp_d   = '0;
          pls_d   = '0;
        end else begin
          nlp_d = nlp_q + NLP_W'(1);
        end
      end
      ST_NLP: begin
        if (pls_q == WID_MAX) begin
          state_d = ST_IDLE;
          nlp_d   = '0;
          pls_d   = '0;
        end else begin
          pls_d = pls_q + PLS_W'(1);
        end
      end
      ST_DATA: begin
        if (boundary && !tx_en) begin
          state_d = ST_SOI;
          pls_d   = '0;
        end
      end
      ST_SOI: begin
        if (pls_q == SOI_MAX) begin
          state_d = ST_IDLE;
          nlp_d   = '0;
          pls_d   = '0;
        end else begin
          pls_d = pls_q + PLS_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new frame bit overrides any pulse or idle timing in progress.
    if (boundary && tx_en) begin
      state_d = ST_DATA;
      nlp_d   = '0;
      pls_d   = '0;
      bit_d   = tx_data;
    end

    // Outputs are computed from next-state values so the registers line up with the state.
    bit_en_d      = phase_d && (hb_d == HB_MAX);
    line_active_d = (state_d != ST_IDLE);
    td_p_d        = 1'b0;
    td_n_d        = 1'b0;
    case (state_d)
      ST_NLP, ST_SOI: td_p_d = 1'b1;
      ST_DATA: begin
        td_p_d = phase_d ? bit_d : ~bit_d;
        td_n_d = ~td_p_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      hb_q          <= '0;
      phase_q       <= 1'b0;
      nlp_q         <= '0;
      pls_q         <= '0;
      bit_q         <= 1'b0;
      bit_en_q      <= 1'b0;
      td_p_q        <= 1'b0;
      td_n_q        <= 1'b0;
      line_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hb_q          <= hb_d;
      phase_q       <= phase_d;
      nlp_q         <= nlp_d;
      pls_q         <= pls_d;
      bit_q         <= bit_d;
      bit_en_q      <= bit_en_d;
      td_p_q        <= td_p_d;
      td_n_q        <= td_n_d;
      line_active_q <= line_active_d;
    end
  end

  assign bit_en      = bit_en_q;
  assign td_p        = td_p_q;
  assign td_n        = td_n_q;
  assign line_active = line_active_q;

endmodule

// File: tb/tb_eth_manchester_tx.sv
// tb/tb_eth_manchester_tx.sv - scoreboard bench for eth_manchester_tx (two parameter sets)
module tb_eth_manchester_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, tx_data, tx_en, tx_idle;
  logic [1:0] bit_en, td_p, td_n, line_active;

  eth_manchester_tx #(
    .HALF_BIT_CYCLES(1), .SOI_CYCLES(5), .NLP_PERIOD_CYCLES(20), .NLP_WIDTH_CYCLES(2)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en[0]), .tx_data(tx_data), .tx_en(tx_en),
    .tx_idle(tx_idle), .td_p(td_p[0]), .td_n(td_n[0]), .line_active(line_active[0])
  );

  eth_manchester_tx #(
    .HALF_BIT_CYCLES(3), .SOI_CYCLES(4), .NLP_PERIOD_CYCLES(30), .NLP_WIDTH_CYCLES(3)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en[1]), .tx_data(tx_data), .tx_en(tx_en),
    .tx_idle(tx_idle), .td_p(td_p[1]), .td_n(td_n[1]), .line_active(line_active[1])
  );

  function automatic int p_h(int k); return (k == 0) ? 1 : 3;  endfunction
  function automatic int p_s(int k); return (k == 0) ? 5 : 4;  endfunction
  function automatic int p_p(int k); return (k == 0) ? 20 : 30; endfunction
  function automatic int p_w(int k); return (k == 0) ? 2 : 3;  endfunction

  typedef enum int {M_IDLE, M_NLP, M_DATA, M_SOI} mode_t;

  // Reference model: line mode plus the absolute cycle at which it began.
  mode_t mode   [2];
  int    t_mode [2];
  int    t_idle [2];
  logic  cur_bit[2];
  int    cyc;

  logic [3:0] exp_q0[$];
  logic [3:0] exp_q1[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  function automatic logic bnd(int k, int c);
    return (c % (2 * p_h(k))) == (2 * p_h(k) - 1);
  endfunction

  // Packed as {td_p, td_n, line_active, bit_en}.
  function automatic logic [3:0] expect_now(int k);
    logic be, tp;
    be = bnd(k, cyc);
    case (mode[k])
      M_IDLE:  return {3'b000, be};
      M_DATA: begin
        tp = (((cyc - t_mode[k]) % (2 * p_h(k))) < p_h(k)) ? ~cur_bit[k] : cur_bit[k];
        return {tp, ~tp, 1'b1, be};
      end
      default: return {3'b101, be};
    endcase
  endfunction

  task automatic push_exp(int k, logic [3:0] v);
    if (k == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  task automatic model_advance(input logic en, input logic d);
    for (int k = 0; k < 2; k++) begin
      int nc;
      nc = cyc + 1;
      if (bnd(k, cyc) && en) begin
        if (mode[k] != M_DATA) t_mode[k] = nc;
        mode[k]    = M_DATA;
        cur_bit[k] = d;
      end else if (bnd(k, cyc) && mode[k] == M_DATA) begin
        mode[k] = M_SOI;  t_mode[k] = nc;
      end else if (mode[k] == M_IDLE && nc - t_idle[k] == p_p(k)) begin
        mode[k] = M_NLP;  t_mode[k] = nc;
      end else if (mode[k] == M_NLP && nc - t_mode[k] == p_w(k)) begin
        mode[k] = M_IDLE; t_idle[k] = nc;
      end else if (mode[k] == M_SOI && nc - t_mode[k] == p_s(k)) begin
        mode[k] = M_IDLE; t_idle[k] = nc;
      end
    end
    cyc++;
    for (int k = 0; k < 2; k++) push_exp(k, expect_now(k));
  endtask

  task automatic step(input logic en, input logic d);
    tx_en   = en;
    tx_data = d;
    tx_idle = 1'($urandom);
    model_advance(en, d);
    @(posedge clk); #1;
  endtask

  task automatic reset_for(input int n);
    rst_n = 1'b0;
    tx_en = 1'b0;
    repeat (n) begin
      push_exp(0, 4'b0000);
      push_exp(1, 4'b0000);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    cyc   = 0;
    for (int k = 0; k < 2; k++) begin
      mode[k] = M_IDLE; t_mode[k] = 0; t_idle[k] = 0; cur_bit[k] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'($urandom));
  endtask

  // Bit i of 'bits' is held until instance 0 samples it at a boundary.
  task automatic send_frame(input int n, input logic [15:0] bits);
    int   idx;
    logic b;
    idx = 0;
    while (idx < n) begin
      b = bnd(0, cyc);
      step(1'b1, bits[idx]);
      if (b) idx++;
    end
    do begin
      b = bnd(0, cyc);
      step(1'b0, 1'($urandom));
    end while (!b);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [3:0] act, exp_v;
        act = {td_p[k], td_n[k], line_active[k], bit_en[k]};
        checks++;
        if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
          errors++;
          $display("FAIL underflow dut%0d t=%0t: got %b, required a queued expectation", k, $time, act);
        end else begin
          exp_v = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          if (act !== exp_v) begin
            errors++;
            $display("FAIL line dut%0d t=%0t cyc=%0d: tdp/tdn/act/ben got %b required %b",
                     k, $time, cyc, act, exp_v);
          end
        end
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    tx_en   = 1'b0;
    tx_data = 1'b0;
    tx_idle = 1'b0;
    cyc     = 0;
    @(posedge clk); #1;
    push_exp(0, 4'b0000);
    push_exp(1, 4'b0000);
    mon_en = 1'b1;
    reset_for(3);

    idle(50);
    send_frame(4, 16'b1101);
    idle(30);

    reset_for(2);
    idle(19);
    send_frame(5, 16'b10110);
    idle(40);

    reset_for(2);
    idle(21);
    send_frame(3, 16'b010);
    idle(30);

    repeat (5) step(1'b1, 1'b1);
    reset_for(1);
    idle(45);

    for (int i = 0; i < 12; i++) begin
      idle($urandom_range(0, 40));
      send_frame($urandom_range(1, 12), 16'($urandom));
    end
    idle(35);

    @(negedge clk); #1;
    mon_en = 1'b0;
    checks++;
    if (exp_q0.size() + exp_q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d leftover expectations, required 0", exp_q0.size() + exp_q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
